// File: rtl/aes_mix_columns_stage_if.sv
// Handshake bundle for the AES MixColumns stage.
//   in_valid/in_ready/in_state/in_last : upstream (post-ShiftRows) state
//   out_valid/out_ready/out_state      : downstream mixed or bypassed state
// The stage uses the slave modport; the upstream/downstream agent uses master.
interface aes_mix_columns_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_last, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_last, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_mix_columns_stage.sv
// Sequential AES MixColumns stage: one 32-bit column per cycle through four
// shared x2/x3 GF(2^8) multiplier lanes. A final-round flag bypasses the mix.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of aes_mix_columns_stage_if (in_* accept, out_* result)
// Byte order: byte 0 = [127:120]; column c = bytes 4c..4c+3.
//
// state | meaning
// IDLE  | waiting for a state; in_ready = 1
// CALC  | mixing column col of the work register, one column per cycle
// DONE  | result registered to out_*, held until out_ready
module aes_mix_columns_stage #(
  parameter int NUM_COLS = 4,
  parameter int CNT_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aes_mix_columns_stage_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [127:0]     work_q, work_d;
  logic             byp_wait_q, byp_wait_d;
  logic             out_valid_q, out_valid_d;
  logic [127:0]     out_state_q, out_state_d;

  logic [31:0]      col_word;
  logic [3:0][7:0]  a;
  logic [3:0][7:0]  m2;
  logic [3:0][7:0]  m3;
  logic [31:0]      mixed;

  // Column select mux feeding the shared multiplier lanes.
  always_comb begin
    col_word = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_q == CNT_W'(c)) col_word = work_q[127-32*c -: 32];
    end
  end

  // Multiplier lanes: lane i handles byte i of the selected column.
  for (genvar i = 0; i < 4; i++) begin : g_mul
    assign a[i]  = col_word[31-8*i -: 8];
    assign m2[i] = {a[i][6:0], 1'b0} ^ (a[i][7] ? 8'h1B : 8'h00);
    assign m3[i] = m2[i] ^ a[i];
  end

  assign mixed = {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
                  a[0]  ^ m2[1] ^ m3[2] ^ a[3],
                  a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
                  m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    work_d      = work_q;
    byp_wait_d  = byp_wait_q;
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.in_state;
          col_d  = '0;
          if (bus.in_last) begin
            state_d    = DONE;
            // Bypass result appears two edges after accept.
            byp_wait_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (col_q == CNT_W'(c)) work_d[127-32*c -: 32] = mixed;
        end
        if (col_q == CNT_W'(NUM_COLS - 1)) begin
          col_d   = '0;
          state_d = DONE;
        end else begin
          col_d = col_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          if (byp_wait_q) begin
            byp_wait_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            out_state_d = work_q;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      work_q      <= '0;
      byp_wait_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      byp_wait_q  <= byp_wait_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_aes_mix_columns_stage.sv
module tb_aes_mix_columns_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_mix_columns_stage_if bus ();

  aes_mix_columns_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [127:0] sb_q[$];

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] b0, b1, b2, b3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = s[127-32*c -: 8];
      b1 = s[119-32*c -: 8];
      b2 = s[111-32*c -: 8];
      b3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(b0) ^ (xt(b1) ^ b1) ^ b2 ^ b3;
      r[119-32*c -: 8] = b0 ^ xt(b1) ^ (xt(b2) ^ b2) ^ b3;
      r[111-32*c -: 8] = b0 ^ b1 ^ xt(b2) ^ (xt(b3) ^ b3);
      r[103-32*c -: 8] = (xt(b0) ^ b0) ^ b1 ^ b2 ^ xt(b3);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one state, wait for acceptance, push its expected result.
  task automatic send(input string tag, input logic [127:0] st, input logic last,
                      input logic [127:0] exp);
    int n;
    bus.in_state = st;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 128'(bus.in_ready), 128'd1);
    sb_q.push_back(exp);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called right after the accept edge; counts edges until out_valid.
  task automatic expect_result(input string tag, input int exp_lat);
    int n;
    logic [127:0] exp;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(exp_lat));
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 128'(sb_q.size()), 128'd1);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_state"}, bus.out_state, exp);
    end
  endtask

  initial begin
    logic [127:0] st, st2, exp_a;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_state", bus.out_state, 128'd0);

    // FIPS-197 round 1, single-cycle pulse
    send("fips", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
         128'h046681e5e0cb199a48f8d37a2806264c);
    expect_result("fips", 5);
    tick();
    chk("fips_pulse", 128'(bus.out_valid), 128'd0);
    chk("fips_idle", 128'(bus.in_ready), 128'd1);

    // Per-column known answers
    send("cols", 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0,
         128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
    expect_result("cols", 5);
    tick();

    // Random vectors against the model
    for (int i = 0; i < 2; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      send("rand", st, 1'b0, model_mix(st));
      expect_result("rand", 5);
      tick();
    end

    // Final-round bypass
    send("bypass", {16{8'hc6}}, 1'b1, {16{8'hc6}});
    expect_result("bypass", 2);
    tick();

    // Backpressure with a second state waiting
    bus.out_ready = 1'b0;
    st  = 128'h0123456789abcdeffedcba9876543210;
    st2 = 128'h95959595_00112233_80808080_deadbeef;
    send("bp_a", st, 1'b0, model_mix(st));
    expect_result("bp_a", 5);
    sb_q.push_front(model_mix(st));
    exp_a = model_mix(st);
    bus.in_state = st2;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid_hold", 128'(bus.out_valid), 128'd1);
      chk("bp_state_hold", bus.out_state, exp_a);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
    end
    void'(sb_q.pop_front());
    sb_q.push_back(model_mix(st2));
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", 128'(bus.out_valid), 128'd0);
    chk("bp_idle", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    expect_result("bp_b", 5);
    tick();

    // Reset asserted mid-CALC (col = 2)
    send("rst_mid", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
         128'h046681e5e0cb199a48f8d37a2806264c);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_mid_state", bus.out_state, 128'd0);
    void'(sb_q.pop_back());
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("rst_no_partial", 128'(bus.out_valid), 128'd0);
    send("post_rst", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
         128'h046681e5e0cb199a48f8d37a2806264c);
    expect_result("post_rst", 5);
    tick();
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
